jb_dl_dfe_sat_stat_agg: RTL and testbench

Parametrised aggregator for DL DFE saturation-error status (PS, carrier interpolator, FIR 3x, polyphase even/odd stages) across NUM_SRC sources. It replaces flat 32-bit status words with three things:
- per-source sticky error bits;
- per-source saturating event counters with atomic snapshot over a 4-phase handshake;
- a masked, level interrupt.

It sits between the DFE datapath saturation detectors and the status register map. The register map reads it through an indexed, registered read port.

---
 rtl/jb_dl_dfe_sat_stat_agg.sv | 146 ++++++++++++++
 tb/tb_jb_dl_dfe_sat_stat_agg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jb_dl_dfe_sat_stat_agg.sv
// DL DFE saturation-status aggregator: per-source sticky bits, saturating event
// counters with a 4-phase snapshot handshake, masked level interrupt.
module jb_dl_dfe_sat_stat_agg #(
  parameter int NUM_SRC = 8,
  parameter int STAT_W  = 32,
  parameter int CNT_W   = 16,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        sat_err_vld,
  input  logic [NUM_SRC*STAT_W-1:0] sat_err,
  input  logic                      clr_stb,
  input  logic [SEL_W-1:0]          clr_src,
  input  logic [STAT_W-1:0]         clr_mask,
  input  logic [NUM_SRC*STAT_W-1:0] irq_mask,
  input  logic                      snap_req,
  output logic                      snap_ack,
  input  logic [SEL_W-1:0]          rd_src,
  output logic [STAT_W-1:0]         rd_sticky,
  output logic [CNT_W-1:0]          rd_cnt,
  output logic                      rd_ovf,
  output logic                      irq
);

  typedef enum logic {IDLE, ACK} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [SEL_W:0]   NUM_SRC_LIM = NUM_SRC[SEL_W:0];

  state_e            state_q, state_d;
  logic [STAT_W-1:0] sticky_q   [NUM_SRC];
  logic [STAT_W-1:0] sticky_d   [NUM_SRC];
  logic [CNT_W-1:0]  live_cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  live_cnt_d [NUM_SRC];
  logic [CNT_W-1:0]  snap_cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  snap_cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] live_ovf_q, live_ovf_d;
  logic [NUM_SRC-1:0] snap_ovf_q, snap_ovf_d;
  logic [STAT_W-1:0] rd_sticky_q, rd_sticky_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rd_ovf_q, rd_ovf_d;
  logic              irq_q, irq_d;

  logic              capture;
  logic              ev;
  logic              at_max;
  logic [STAT_W-1:0] set_bits;
  logic [STAT_W-1:0] clr_bits;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;
  logic              rd_in_range;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sticky_d    = sticky_q;
    live_cnt_d  = live_cnt_q;
    snap_cnt_d  = snap_cnt_q;
    live_ovf_d  = live_ovf_q;
    snap_ovf_d  = snap_ovf_q;
    irq_d       = 1'b0;
    ev          = 1'b0;
    at_max      = 1'b0;
    set_bits    = '0;
    clr_bits    = '0;
    cnt_nxt     = '0;
    ovf_nxt     = 1'b0;

    capture = (state_q == IDLE) && snap_req;
    case (state_q)
      IDLE:    if (snap_req)  state_d = ACK;
      ACK:     if (!snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_SRC; i++) begin
      set_bits = sat_err_vld[i] ? sat_err[i*STAT_W +: STAT_W] : '0;
      // Index compare cannot alias: i < NUM_SRC <= 2**SEL_W, so out-of-range
      // clr_src values simply match nothing.
      clr_bits = (clr_stb && (clr_src == SEL_W'(i))) ? clr_mask : '0;
      sticky_d[i] = (sticky_q[i] & ~clr_bits) | set_bits;

      ev      = sat_err_vld[i] && (|sat_err[i*STAT_W +: STAT_W]);
      at_max  = (live_cnt_q[i] == CNT_MAX);
      cnt_nxt = (ev && !at_max) ? live_cnt_q[i] + CNT_W'(1) : live_cnt_q[i];
      ovf_nxt = live_ovf_q[i] | (ev & at_max);

      // The capture-cycle event closes into the snapshot; the new window starts empty.
      if (capture) begin
        snap_cnt_d[i] = cnt_nxt;
        snap_ovf_d[i] = ovf_nxt;
        live_cnt_d[i] = '0;
        live_ovf_d[i] = 1'b0;
      end else begin
        live_cnt_d[i] = cnt_nxt;
        live_ovf_d[i] = ovf_nxt;
      end

      irq_d = irq_d | (|(sticky_q[i] & irq_mask[i*STAT_W +: STAT_W]));
    end

    rd_in_range = ({1'b0, rd_src} < NUM_SRC_LIM);
    rd_sticky_d = rd_in_range ? sticky_q[rd_src]   : '0;
    rd_cnt_d    = rd_in_range ? snap_cnt_q[rd_src] : '0;
    rd_ovf_d    = rd_in_range ? snap_ovf_q[rd_src] : 1'b0;
  end

  // NOTE: the per-source arrays are architectural state read by software, so
  // they are reset explicitly rather than left to power-up values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      live_ovf_q  <= '0;
      snap_ovf_q  <= '0;
      rd_sticky_q <= '0;
      rd_cnt_q    <= '0;
      rd_ovf_q    <= 1'b0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        sticky_q[i]   <= '0;
        live_cnt_q[i] <= '0;
        snap_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      live_ovf_q  <= live_ovf_d;
      snap_ovf_q  <= snap_ovf_d;
      rd_sticky_q <= rd_sticky_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_ovf_q    <= rd_ovf_d;
      irq_q       <= irq_d;
      sticky_q    <= sticky_d;
      live_cnt_q  <= live_cnt_d;
      snap_cnt_q  <= snap_cnt_d;
    end
  end

  assign snap_ack  = (state_q == ACK);
  assign rd_sticky = rd_sticky_q;
  assign rd_cnt    = rd_cnt_q;
  assign rd_ovf    = rd_ovf_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_jb_dl_dfe_sat_stat_agg.sv
// Directed bench for jb_dl_dfe_sat_stat_agg with a 4-bit counter so saturation
// is reachable in a few cycles.
module tb_jb_dl_dfe_sat_stat_agg;

  localparam int NUM_SRC = 8;
  localparam int STAT_W  = 32;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        sat_err_vld;
  logic [NUM_SRC*STAT_W-1:0] sat_err;
  logic                      clr_stb;
  logic [SEL_W-1:0]          clr_src;
  logic [STAT_W-1:0]         clr_mask;
  logic [NUM_SRC*STAT_W-1:0] irq_mask;
  logic                      snap_req;
  logic                      snap_ack;
  logic [SEL_W-1:0]          rd_src;
  logic [STAT_W-1:0]         rd_sticky;
  logic [CNT_W-1:0]          rd_cnt;
  logic                      rd_ovf;
  logic                      irq;

  int n_pass  = 0;
  int n_total = 0;

  jb_dl_dfe_sat_stat_agg #(
    .NUM_SRC(NUM_SRC), .STAT_W(STAT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .sat_err_vld(sat_err_vld), .sat_err(sat_err),
    .clr_stb(clr_stb), .clr_src(clr_src), .clr_mask(clr_mask),
    .irq_mask(irq_mask),
    .snap_req(snap_req), .snap_ack(snap_ack),
    .rd_src(rd_src), .rd_sticky(rd_sticky), .rd_cnt(rd_cnt), .rd_ovf(rd_ovf),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic quiet();
    sat_err_vld = '0;
    sat_err     = '0;
    clr_stb     = 1'b0;
    clr_src     = '0;
    clr_mask    = '0;
  endtask

  task automatic event_on(input int src, input int bitn);
    sat_err_vld[src]            = 1'b1;
    sat_err[src*STAT_W + bitn]  = 1'b1;
  endtask

  initial begin
    // 1. Reset with random inputs
    rst         = 1'b1;
    sat_err_vld = NUM_SRC'($urandom());
    for (int i = 0; i < NUM_SRC; i++) begin
      sat_err[i*STAT_W +: STAT_W]  = $urandom();
      irq_mask[i*STAT_W +: STAT_W] = $urandom();
    end
    clr_stb  = 1'b1;
    clr_src  = SEL_W'($urandom());
    clr_mask = $urandom();
    snap_req = 1'b1;
    rd_src   = SEL_W'($urandom());
    repeat (3) tick();
    check("rst_snap_ack", snap_ack, 0);
    check("rst_rd_sticky", rd_sticky, 0);
    check("rst_rd_cnt", rd_cnt, 0);
    check("rst_rd_ovf", rd_ovf, 0);
    check("rst_irq", irq, 0);

    quiet();
    irq_mask = '0;
    snap_req = 1'b0;
    rd_src   = 3'd0;
    rst      = 1'b0;
    tick();
    check("post_rst_rd_cnt", rd_cnt, 0);
    check("post_rst_irq", irq, 0);
    check("post_rst_ack", snap_ack, 0);

    // 2. Sticky set / clear collision on src 2 bit 5
    rd_src = 3'd2;
    event_on(2, 5);
    tick();
    quiet();
    tick();
    check("sticky_set", rd_sticky, 32'h20);

    event_on(2, 5);
    clr_stb = 1'b1; clr_src = 3'd2; clr_mask = 32'h20;
    tick();
    quiet();
    tick();
    check("sticky_set_wins", rd_sticky, 32'h20);

    clr_stb = 1'b1; clr_src = 3'd3; clr_mask = 32'hFFFF_FFFF;
    tick();
    quiet();
    tick();
    check("sticky_other_src_clr", rd_sticky, 32'h20);

    clr_stb = 1'b1; clr_src = 3'd2; clr_mask = 32'h20;
    tick();
    quiet();
    tick();
    check("sticky_cleared", rd_sticky, 32'h0);

    // 3. Counter saturation on src 0 (15 max, 20 events)
    rd_src = 3'd0;
    event_on(0, 0);
    repeat (20) tick();
    quiet();
    snap_req = 1'b1;
    tick();
    check("sat_ack_hi", snap_ack, 1);
    tick();
    check("sat_rd_cnt", rd_cnt, 15);
    check("sat_rd_ovf", rd_ovf, 1);
    check("sat_ack_held", snap_ack, 1);
    snap_req = 1'b0;
    tick();
    check("sat_ack_lo", snap_ack, 0);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    check("snap2_rd_cnt", rd_cnt, 0);
    check("snap2_rd_ovf", rd_ovf, 0);
    check("snap2_ack_lo", snap_ack, 0);

    // 4. Snapshot atomicity on src 1
    rd_src = 3'd1;
    event_on(1, 0);
    repeat (7) tick();
    check("atom_ack_before", snap_ack, 0);
    snap_req = 1'b1;
    tick();
    check("atom_ack_hi", snap_ack, 1);
    repeat (3) tick();
    quiet();
    check("atom_rd_cnt", rd_cnt, 8);
    check("atom_rd_ovf", rd_ovf, 0);
    check("atom_ack_held", snap_ack, 1);
    snap_req = 1'b0;
    tick();
    check("atom_ack_lo", snap_ack, 0);
    snap_req = 1'b1;
    tick();
    tick();
    check("atom2_rd_cnt", rd_cnt, 3);
    snap_req = 1'b0;
    tick();

    // 5. IRQ masking: only src 7 bit 31 enabled
    irq_mask = '0;
    irq_mask[7*STAT_W + 31] = 1'b1;
    tick();
    check("irq_masked_idle", irq, 0);
    event_on(0, 31);
    tick();
    quiet();
    tick();
    check("irq_wrong_src", irq, 0);
    event_on(7, 31);
    tick();
    quiet();
    check("irq_n1", irq, 0);
    tick();
    check("irq_n2", irq, 1);
    clr_stb = 1'b1; clr_src = 3'd7; clr_mask = 32'h8000_0000;
    tick();
    quiet();
    check("irq_clr_n1", irq, 1);
    tick();
    check("irq_clr_n2", irq, 0);

    // 6. Reset mid-handshake
    snap_req = 1'b1;
    tick();
    check("mid_ack_hi", snap_ack, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_ack", snap_ack, 0);
    rst = 1'b0;
    tick();
    check("mid_fresh_ack", snap_ack, 1);
    snap_req = 1'b0;
    tick();
    check("mid_final_ack", snap_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
